// File: rtl/chip8_display.sv
// chip8_display: sprite-draw engine and 64x32 monochrome framebuffer for the CHIP-8 core.
// Each draw handshake XORs one sprite row into the framebuffer. The engine reports
// display_done and collision back to the CPU, runs clear-screen, and offers a read port for scanout.
// Optional build macro CHIP8_DISP_CLIP_EN: clip sprites at the screen edges instead of wrapping.
module chip8_display #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw,
    input  logic [5:0] x,
    input  logic [4:0] y,
    input  logic [7:0] sprite_data,
    input  logic [3:0] draw_row_index,
    input  logic       cls,
    input  logic [7:0] vid_addr,
    output logic [7:0] vid_data,
    output logic       display_done,
    output logic       collision,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD_L,
        WR_L,
        RD_R,
        WR_R,
        CLEAR,
        DONE,
        REARM
    } state_t;

    state_t state, state_next;

    // 256 bytes: byte row*8 + col/8, bit 7 is the leftmost pixel of the byte
    logic [7:0] fb [0:255];

    logic [7:0] cnt;
    logic [4:0] row;
    logic [2:0] ba;
    logic [2:0] sh;
    logic [7:0] mask_l;
    logic [7:0] mask_r;
    logic       coll_acc;
    logic       coll_acc_next;

    logic [7:0] rdata;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;

    logic [15:0] shifted;
    logic [4:0]  row_in;
    logic        start_draw;

    assign start_draw = (state == IDLE) && !cls && draw;

    // The sprite byte is spread over two framebuffer bytes: the upper half is the left part, the lower half spills right
    assign shifted = {sprite_data, 8'h00} >> x[2:0];

`ifdef CHIP8_DISP_CLIP_EN
    logic [5:0] row_sum;
    logic       row_off_screen;

    assign row_sum        = {1'b0, y} + {2'b00, draw_row_index};
    assign row_in         = row_sum[4:0];
    assign row_off_screen = row_sum > 6'd31;
`else
    assign row_in = y + {1'b0, draw_row_index};
`endif

    // Next-state logic and port A control: address, write enable and write data
    always_comb begin
        state_next    = state;
        mem_we        = 1'b0;
        mem_addr      = {row, ba};
        mem_wdata     = 8'h00;
        coll_acc_next = coll_acc;
        case (state)
            IDLE: begin
                coll_acc_next = 1'b0;
                if (cls) begin
                    state_next = CLEAR;
                end else if (draw) begin
`ifdef CHIP8_DISP_CLIP_EN
                    state_next = row_off_screen ? DONE : RD_L;
`else
                    state_next = RD_L;
`endif
                end
            end
            RD_L: begin
                mem_addr   = {row, ba};
                state_next = WR_L;
            end
            WR_L: begin
                mem_addr      = {row, ba};
                mem_we        = 1'b1;
                mem_wdata     = rdata ^ mask_l;
                coll_acc_next = coll_acc | (|(rdata & mask_l));
`ifdef CHIP8_DISP_CLIP_EN
                state_next    = ((sh == 3'd0) || (ba == 3'd7)) ? DONE : RD_R;
`else
                state_next    = (sh == 3'd0) ? DONE : RD_R;
`endif
            end
            RD_R: begin
                mem_addr   = {row, ba + 3'd1};
                state_next = WR_R;
            end
            WR_R: begin
                mem_addr      = {row, ba + 3'd1};
                mem_we        = 1'b1;
                mem_wdata     = rdata ^ mask_r;
                coll_acc_next = coll_acc | (|(rdata & mask_r));
                state_next    = DONE;
            end
            CLEAR: begin
                mem_addr   = cnt;
                mem_we     = 1'b1;
                mem_wdata  = 8'h00;
                if (cnt == 8'd255) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = REARM;
            end
            REARM: begin
                if (!draw) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // State register, draw latches, clear counter and the registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt          <= 8'd0;
            row          <= 5'd0;
            ba           <= 3'd0;
            sh           <= 3'd0;
            mask_l       <= 8'h00;
            mask_r       <= 8'h00;
            coll_acc     <= 1'b0;
            display_done <= 1'b0;
            collision    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state    <= state_next;
            coll_acc <= coll_acc_next;
            if (start_draw) begin
                row    <= row_in;
                ba     <= x[5:3];
                sh     <= x[2:0];
                mask_l <= shifted[15:8];
                mask_r <= shifted[7:0];
            end
            if ((state == IDLE) && cls) begin
                cnt <= 8'd0;
            end else if (state == CLEAR) begin
                cnt <= cnt + 8'd1;
            end
            display_done <= (state_next == DONE);
            collision    <= (state_next == DONE) && coll_acc_next;
            busy         <= (state_next != IDLE) && (state_next != REARM);
        end
    end

    // Port A: synchronous read/write for the engine; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            fb[mem_addr] <= mem_wdata;
        end
        rdata <= fb[mem_addr];
    end

    // Port B: scanout read, registered every cycle; a same-cycle write returns the old byte
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_data <= 8'h00;
        end else begin
            vid_data <= fb[vid_addr];
        end
    end

endmodule
